// File: rtl/uart_rx_param_if.sv
// Receiver-side signal bundle for uart_rx_param: the serial input plus the
// parallel word, its ready strobe, error flags and the busy indicator.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rx,
        output data, ready, parity_err, frame_err, busy
    );

    modport slave (
        output rx,
        input  data, ready, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable width, divisor, parity and stop bits,
// with start-bit glitch rejection, parity/framing error flags and break lockout.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_param_if.master bus
);
    localparam int   CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int   IDX_W   = $clog2(DATA_BITS);
    localparam logic PAR_EXP = (PARITY == 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;
    logic                 rx_s;
    logic                 last_stop;
    logic                 frame_bad;

    assign rx_s      = sync2_q;
    assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
    assign frame_bad = ferr_acc_q | ~rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop_idx_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            stop_idx_q <= stop_idx_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop_idx_d = stop_idx_q;
        ferr_acc_d = ferr_acc_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ready_d    = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        idx_d      = '0;
                        stop_idx_d = 1'b0;
                        ferr_acc_d = 1'b0;
                        state_d    = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PAR: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (last_stop) begin
                        // Word is delivered even when flags are set.
                        data_d     = shift_q;
                        perr_d     = (PARITY != 0) && ((^shift_q ^ par_q) != PAR_EXP);
                        ferr_d     = frame_bad;
                        ready_d    = 1'b1;
                        busy_d     = 1'b0;
                        stop_idx_d = 1'b0;
                        state_d    = frame_bad ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                        ferr_acc_d = frame_bad;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.data       = data_q;
    assign bus.ready      = ready_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations (8N1, 8E1, 7N2)
// driven with hand-built serial frames; results checked against fixed values.
module tb_uart_rx_param;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   rdy_cnt [3] = '{0, 0, 0};
    int   rdy_cyc [3] = '{0, 0, 0};
    int   t_start = 0;
    bit   busy_seen = 1'b0;

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(8)) if1 ();
    uart_rx_param_if #(.DATA_BITS(7)) if2 ();

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u0 (.clk(clk), .rst(rst), .bus(if0.master));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        u1 (.clk(clk), .rst(rst), .bus(if1.master));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
        u2 (.clk(clk), .rst(rst), .bus(if2.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (if0.ready) begin rdy_cnt[0] += 1; rdy_cyc[0] = cyc; end
        if (if1.ready) begin rdy_cnt[1] += 1; rdy_cyc[1] = cyc; end
        if (if2.ready) begin rdy_cnt[2] += 1; rdy_cyc[2] = cyc; end
        if (if0.busy) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total += 1;
        if (obs !== exp) begin
            bad += 1;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic b);
        case (sel)
            0: if0.rx = b;
            1: if1.rx = b;
            default: if2.rx = b;
        endcase
    endtask

    task automatic drive_bit(input int sel, input logic b);
        set_line(sel, b);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [8:0] w, input int nd,
                              input int par, input bit flip, input int ns,
                              input bit stop2_low);
        logic p;
        p = 1'b0;
        t_start = cyc;
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nd; i++) begin
            drive_bit(sel, w[i]);
            p = p ^ w[i];
        end
        if (par != 0) begin
            if (par == 1) p = ~p;
            if (flip) p = ~p;
            drive_bit(sel, p);
        end
        drive_bit(sel, 1'b1);
        if (ns == 2) drive_bit(sel, stop2_low ? 1'b0 : 1'b1);
        set_line(sel, 1'b1);
    endtask

    initial begin
        int lat;
        if0.rx = 1'b1;
        if1.rx = 1'b1;
        if2.rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(if0.data), 32'h0);
        chk("rst_ready", 32'(if0.ready), 32'h0);
        chk("rst_perr", 32'(if0.parity_err), 32'h0);
        chk("rst_ferr", 32'(if0.frame_err), 32'h0);
        chk("rst_busy", 32'(if0.busy), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 single frame plus latency
        send_frame(0, 9'h41, 8, 0, 1'b0, 1, 1'b0);
        repeat (10) @(negedge clk);
        lat = rdy_cyc[0] - t_start;
        chk("f41_cnt", 32'(rdy_cnt[0]), 32'd1);
        chk("f41_data", 32'(if0.data), 32'h41);
        chk("f41_perr", 32'(if0.parity_err), 32'h0);
        chk("f41_ferr", 32'(if0.frame_err), 32'h0);
        chk("f41_lat", 32'(lat >= 77 && lat <= 79), 32'd1);

        // Even parity, gapless pair then a pair with a corrupted parity bit
        send_frame(1, 9'h55, 8, 2, 1'b0, 1, 1'b0);
        chk("p55_cnt", 32'(rdy_cnt[1]), 32'd1);
        chk("p55_data", 32'(if1.data), 32'h55);
        chk("p55_perr", 32'(if1.parity_err), 32'h0);
        send_frame(1, 9'hA3, 8, 2, 1'b0, 1, 1'b0);
        repeat (10) @(negedge clk);
        chk("pa3_cnt", 32'(rdy_cnt[1]), 32'd2);
        chk("pa3_data", 32'(if1.data), 32'hA3);
        chk("pa3_perr", 32'(if1.parity_err), 32'h0);
        chk("pa3_ferr", 32'(if1.frame_err), 32'h0);
        send_frame(1, 9'h55, 8, 2, 1'b0, 1, 1'b0);
        send_frame(1, 9'hA3, 8, 2, 1'b1, 1, 1'b0);
        repeat (10) @(negedge clk);
        chk("bad_par_cnt", 32'(rdy_cnt[1]), 32'd4);
        chk("bad_par_data", 32'(if1.data), 32'hA3);
        chk("bad_par_perr", 32'(if1.parity_err), 32'h1);

        // Start-bit glitch shorter than half a bit
        busy_seen = 1'b0;
        if0.rx = 1'b0;
        repeat (3) @(negedge clk);
        if0.rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("gl_busy_seen", 32'(busy_seen), 32'h1);
        chk("gl_busy", 32'(if0.busy), 32'h0);
        chk("gl_cnt", 32'(rdy_cnt[0]), 32'd1);
        chk("gl_data", 32'(if0.data), 32'h41);

        // Break: one errored word, then lockout until the line returns high
        if0.rx = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        chk("brk_cnt", 32'(rdy_cnt[0]), 32'd2);
        chk("brk_data", 32'(if0.data), 32'h0);
        chk("brk_ferr", 32'(if0.frame_err), 32'h1);
        chk("brk_busy", 32'(if0.busy), 32'h0);
        if0.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("brk_rel_cnt", 32'(rdy_cnt[0]), 32'd2);
        send_frame(0, 9'h7E, 8, 0, 1'b0, 1, 1'b0);
        repeat (10) @(negedge clk);
        chk("f7e_cnt", 32'(rdy_cnt[0]), 32'd3);
        chk("f7e_data", 32'(if0.data), 32'h7E);
        chk("f7e_ferr", 32'(if0.frame_err), 32'h0);

        // 7 data bits, two stop bits
        send_frame(2, 9'h2A, 7, 0, 1'b0, 2, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        chk("s2_bad_cnt", 32'(rdy_cnt[2]), 32'd1);
        chk("s2_bad_data", 32'(if2.data), 32'h2A);
        chk("s2_bad_ferr", 32'(if2.frame_err), 32'h1);
        send_frame(2, 9'h2A, 7, 0, 1'b0, 2, 1'b0);
        repeat (10) @(negedge clk);
        chk("s2_ok_cnt", 32'(rdy_cnt[2]), 32'd2);
        chk("s2_ok_data", 32'(if2.data), 32'h2A);
        chk("s2_ok_ferr", 32'(if2.frame_err), 32'h0);

        // Reset in the middle of frame 0x33
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, (8'h33 >> i) & 8'h1);
        rst = 1'b1;
        if0.rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        chk("mr_cnt", 32'(rdy_cnt[0]), 32'd3);
        chk("mr_data", 32'(if0.data), 32'h0);
        chk("mr_ferr", 32'(if0.frame_err), 32'h0);
        chk("mr_perr", 32'(if0.parity_err), 32'h0);
        chk("mr_busy", 32'(if0.busy), 32'h0);
        send_frame(0, 9'hC4, 8, 0, 1'b0, 1, 1'b0);
        repeat (10) @(negedge clk);
        chk("fc4_cnt", 32'(rdy_cnt[0]), 32'd4);
        chk("fc4_data", 32'(if0.data), 32'hC4);
        chk("fc4_ferr", 32'(if0.frame_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver. It replaces the fixed 8N1 receiver with configurable data width, baud divisor, parity mode and stop-bit count. It adds glitch rejection plus parity and framing error reporting. It sits on the serial input pin, can be paired back-to-back with the transmitter in loopback benches, and delivers one parallel word per frame with a single-cycle ready strobe.

Parameters:
CLKS_PER_BIT, 8, clk cycles per serial bit; even, >= 4
DATA_BITS, 8, payload bits per frame; 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; 1 or 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line; idle high; asynchronous to clk
data  output  DATA_BITS  last received word, LSB received first
ready  output  1  one-cycle pulse when data, parity_err and frame_err are updated
parity_err  output  1  parity mismatch on last frame; 0 when PARITY = 0
frame_err  output  1  any stop bit sampled low on last frame
busy  output  1  high from start-bit detect until ready or frame abort

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: data = 0, ready = 0, parity_err = 0, frame_err = 0, busy = 0, state = IDLE, both synchroniser flops = 1, counters = 0.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only.
- One baud counter (0..CLKS_PER_BIT-1) and one bit index (0..DATA_BITS-1).
- IDLE: rx_s == 0 → START, counter cleared, busy = 1.
- START: on counter == CLKS_PER_BIT/2-1, sample rx_s.
  - 0 → DATA, counter cleared.
  - 1 → glitch: back to IDLE, busy = 0, no ready, outputs unchanged.
- DATA: on counter == CLKS_PER_BIT-1, shift rx_s into the shift register at position [index], LSB first.
  - After the bit at index DATA_BITS-1 → PARITY if PARITY != 0, else STOP.
  - Sampling points are mid-bit.
- PARITY: sample one bit. Error flag = (XOR of data bits XOR parity bit) != expected, where expected is 1 for odd and 0 for even. → STOP.
- STOP: sample STOP_BITS bits at the same mid-bit spacing. frame_err_next = OR of (stop sample == 0).
  - After the last stop sample: the same cycle loads data, parity_err and frame_err, pulses ready for exactly one cycle and drops busy.
  - Next state is IDLE if frame is good, else WAIT_HIGH.
- WAIT_HIGH: stay until rx_s == 1, then IDLE. This stops a break condition (line held low) from spawning back-to-back false frames. Only one ready is produced per break.
- Latency: the ready pulse lands 2 + CLKS_PER_BIT/2 + (DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT clk cycles after the rx falling edge, ±1 cycle for synchroniser phase.
- Output hold: data and error flags hold their values until the next ready. Errors do not suppress data; the word is delivered with flags set.
- Back-to-back frames: a start bit beginning right after the last stop bit's mid-point is accepted. IDLE is re-entered the cycle after the final sample, so no gap is required.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded and no ready is produced. After release, a line already low is treated as a new start bit.
- Widths: data is exactly DATA_BITS wide. With DATA_BITS = 9 the parity XOR covers all 9 bits.

Test Plan:
- Default params, CLKS_PER_BIT = 8. Transmit 0x41 8N1 from uart_tx in loopback → one ready pulse, data = 0x41, parity_err = 0, frame_err = 0. Pulse timing within ±1 cycle of the latency formula (78 cycles).
- PARITY = 2, two frames 0x55 then 0xA3, gapless → two ready pulses, data 0x55 then 0xA3, no errors. Repeat with the parity bit of 0xA3 inverted → second frame parity_err = 1, data = 0xA3.
- Glitch: rx low for 3 clk cycles then high (< CLKS_PER_BIT/2) → busy pulses and returns to 0, no ready, data keeps the previous value.
- Break: rx held low for 30 bit times, then released high, then a valid 0x7E frame → exactly one ready with frame_err = 1 and data = 0x00 during the break. Then one ready with data = 0x7E and frame_err = 0.
- STOP_BITS = 2, DATA_BITS = 7: frame 0x2A whose second stop bit is driven low → data = 0x2A, frame_err = 1. Same frame with valid stops → frame_err = 0.
- Assert rst for 2 cycles midway through the data bits of frame 0x33 → no ready, all outputs 0. A following 0xC4 frame is received correctly.
